exception_dispatch_unit: RTL and testbench

Consumes the registered exception-trigger bus from the controller and the external interrupt lines. Prioritises them and captures cause, exception PC and faulting address. Redirects fetch to a per-cause vector through a valid/ready handshake. Tracks handler residency, handles return-from-exception, and escalates a synchronous fault inside a handler to a double fault and halt.

---
 rtl/exception_dispatch_unit.sv | 151 +++++++++++++++
 tb/tb_exception_dispatch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_dispatch_unit.sv
// Exception/interrupt dispatch: prioritises sync traps over IRQs, latches cause/epc/bad_addr,
// redirects fetch through a valid/ready handshake, and escalates a fault inside a handler to halt.
module exception_dispatch_unit #(
  parameter int unsigned IRQ_COUNT     = 8,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter int unsigned VECTOR_STRIDE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           trigger,
  input  logic [31:0]          pc_current,
  input  logic [31:0]          pc_next,
  input  logic [31:0]          data_addr,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic                 instr_boundary,
  input  logic                 eret,
  input  logic                 gie_we,
  input  logic                 gie_wdata,
  input  logic                 redirect_ready,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_addr,
  output logic                 flush,
  output logic [4:0]           cause,
  output logic [31:0]          epc,
  output logic [31:0]          bad_addr,
  output logic                 gie,
  output logic                 in_handler,
  output logic                 halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_REDIRECT, S_HANDLER, S_RETURN, S_HALT
  } state_t;

  localparam logic [2:0] T_INSTA  = 3'd1;
  localparam logic [2:0] T_SYS    = 3'd3;
  localparam logic [2:0] T_DATAA  = 3'd5;
  localparam logic [4:0] C_DOUBLE = 5'd6;

  state_t      state;
  logic        pgie;
  logic        flush_r;
  logic        sync_vld;
  logic        irq_hit;
  logic [3:0]  irq_idx;
  logic [4:0]  new_cause;
  logic [31:0] new_epc;
  logic [31:0] new_bad;
  logic        accept;

  function automatic logic [31:0] vec_addr(input logic [4:0] c);
    return VECTOR_BASE + 32'(c) * 32'(VECTOR_STRIDE);
  endfunction

  // Scan high-to-low so the lowest asserted line is the one left standing.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_hit = 1'b1;
        irq_idx = 4'(i);
      end
    end
  end

  assign sync_vld  = (trigger >= 3'd1) && (trigger <= 3'd5);
  assign new_cause = sync_vld ? {2'b00, trigger} : {1'b1, irq_idx};
  assign new_epc   = (sync_vld && trigger != T_SYS) ? pc_current : pc_next;
  assign new_bad   = (trigger == T_INSTA) ? pc_current :
                     (trigger == T_DATAA) ? data_addr  : 32'h0;
  assign accept    = redirect_valid && redirect_ready;
  assign flush     = flush_r && enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      gie            <= 1'b0;
      pgie           <= 1'b0;
      cause          <= '0;
      epc            <= '0;
      bad_addr       <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      flush_r        <= 1'b0;
      in_handler     <= 1'b0;
      halted         <= 1'b0;
    end else if (enable) begin
      flush_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sync_vld || (gie && instr_boundary && irq_hit)) begin
            cause          <= new_cause;
            epc            <= new_epc;
            bad_addr       <= new_bad;
            pgie           <= gie;
            gie            <= 1'b0;
            flush_r        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_addr  <= vec_addr(new_cause);
            state          <= S_CAPTURE;
          end else if (gie_we) begin
            gie <= gie_wdata;
          end
        end
        S_CAPTURE, S_REDIRECT: begin
          if (accept) begin
            redirect_valid <= 1'b0;
            in_handler     <= 1'b1;
            state          <= S_HANDLER;
          end else begin
            state <= S_REDIRECT;
          end
        end
        S_HANDLER: begin
          if (gie_we) pgie <= gie_wdata;
          // A fault while already handling one is unrecoverable; it also beats eret.
          if (sync_vld) begin
            cause          <= C_DOUBLE;
            epc            <= pc_current;
            flush_r        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_addr  <= vec_addr(C_DOUBLE);
            in_handler     <= 1'b0;
            halted         <= 1'b1;
            state          <= S_HALT;
          end else if (eret) begin
            gie            <= pgie;
            flush_r        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_addr  <= epc;
            state          <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (accept) begin
            redirect_valid <= 1'b0;
            in_handler     <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_HALT: begin
          if (accept) redirect_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_dispatch_unit.sv
// Bench for exception_dispatch_unit: redirects are scoreboarded at handshake time,
// state/outputs are spot-checked between cycles.
module tb_exception_dispatch_unit;

  localparam int IRQ_COUNT = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] bad;
  } redir_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [2:0]           trigger;
  logic [31:0]          pc_current, pc_next, data_addr;
  logic [IRQ_COUNT-1:0] irq;
  logic                 instr_boundary, eret, gie_we, gie_wdata, redirect_ready;
  logic                 redirect_valid, flush, gie, in_handler, halted;
  logic [31:0]          redirect_addr, epc, bad_addr;
  logic [4:0]           cause;

  int n_chk = 0;
  int n_err = 0;
  redir_t sb[$];

  exception_dispatch_unit #(.IRQ_COUNT(IRQ_COUNT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .pc_current(pc_current), .pc_next(pc_next), .data_addr(data_addr),
    .irq(irq), .instr_boundary(instr_boundary), .eret(eret),
    .gie_we(gie_we), .gie_wdata(gie_wdata), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .flush(flush),
    .cause(cause), .epc(epc), .bad_addr(bad_addr), .gie(gie),
    .in_handler(in_handler), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [4:0] c,
                      input logic [31:0] e, input logic [31:0] b);
    redir_t r;
    r.addr = a; r.cause = c; r.epc = e; r.bad = b;
    sb.push_back(r);
  endtask

  // Handshake will complete on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && enable && redirect_valid && redirect_ready) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        redir_t r;
        r = sb.pop_front();
        chk("sb_addr",  redirect_addr, r.addr);
        chk("sb_cause", 32'(cause),    32'(r.cause));
        chk("sb_epc",   epc,           r.epc);
        chk("sb_bad",   bad_addr,      r.bad);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; trigger = '0; pc_current = '0; pc_next = '0;
    data_addr = '0; irq = '0; instr_boundary = 1'b0; eret = 1'b0;
    gie_we = 1'b0; gie_wdata = 1'b0; redirect_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_valid", 32'(redirect_valid), 0);
    chk("rst_addr",  redirect_addr, 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_epc",   epc, 0);
    chk("rst_bad",   bad_addr, 0);
    chk("rst_misc",  {28'd0, gie, in_handler, halted, flush}, 0);

    // SYS trap with a simultaneous gie write: capture wins.
    gie_we = 1'b1; gie_wdata = 1'b1; trigger = 3'd3;
    pc_current = 32'h1000; pc_next = 32'h1004;
    push(32'h130, 5'd3, 32'h1004, 32'h0);
    step(1);
    gie_we = 1'b0; trigger = '0;
    chk("sys_gie",   32'(gie), 0);
    chk("sys_flush", 32'(flush), 1);
    chk("sys_addr",  redirect_addr, 32'h130);
    step(1);
    chk("sys_flush1", 32'(flush), 0);
    chk("sys_valid",  32'(redirect_valid), 1);
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("sys_inh",   32'(in_handler), 1);
    chk("sys_vld0",  32'(redirect_valid), 0);

    // In handler: gie_we targets pgie; eret restores it and returns to epc.
    gie_we = 1'b1; gie_wdata = 1'b1;
    step(1);
    gie_we = 1'b0;
    chk("h_gie_held", 32'(gie), 0);
    eret = 1'b1;
    push(32'h1004, 5'd3, 32'h1004, 32'h0);
    step(1);
    eret = 1'b0;
    chk("ret_gie",   32'(gie), 1);
    chk("ret_flush", 32'(flush), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("ret_hold_v", 32'(redirect_valid), 1);
      chk("ret_hold_a", redirect_addr, 32'h1004);
    end
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("ret_idle", {30'd0, in_handler, redirect_valid}, 0);

    // DATAA beats irq[0]; ready already high in CAPTURE.
    trigger = 3'd5; data_addr = 32'h2003; pc_current = 32'h2000; irq = 8'h01;
    instr_boundary = 1'b1;
    push(32'h150, 5'd5, 32'h2000, 32'h2003);
    step(1);
    trigger = '0; irq = '0; instr_boundary = 1'b0;
    chk("da_cause", 32'(cause), 5);
    chk("da_bad",   bad_addr, 32'h2003);
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("da_inh", 32'(in_handler), 1);
    eret = 1'b1;
    push(32'h2000, 5'd5, 32'h2000, 32'h2003);
    step(1);
    eret = 1'b0; redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("da_gie", 32'(gie), 1);

    // IRQ waits for an instruction boundary, then lowest line (2) wins.
    irq = 8'b0010_0100; pc_next = 32'h3004; pc_current = 32'h3000;
    step(3);
    chk("irq_nobnd", 32'(redirect_valid), 0);
    instr_boundary = 1'b1;
    push(32'h220, 5'd18, 32'h3004, 32'h0);
    step(1);
    irq = '0; instr_boundary = 1'b0;
    chk("irq_cause", 32'(cause), 18);
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;

    // Fault plus eret inside handler -> double fault and halt.
    trigger = 3'd4; eret = 1'b1; pc_current = 32'h3100;
    push(32'h160, 5'd6, 32'h3100, 32'h0);
    step(1);
    trigger = '0; eret = 1'b0;
    chk("df_halt", {30'd0, halted, in_handler}, 32'b10);
    chk("df_gie",  32'(gie), 0);
    step(1);
    chk("df_hold", 32'(redirect_valid), 1);
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    trigger = 3'd2;
    step(2);
    trigger = '0;
    chk("df_stay", {30'd0, halted, redirect_valid}, 32'b10);

    // Reset out of HALT, then stall during CAPTURE/REDIRECT.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    trigger = 3'd1; pc_current = 32'h4000;
    push(32'h110, 5'd1, 32'h4000, 32'h4000);
    step(1);
    trigger = '0;
    enable = 1'b0; redirect_ready = 1'b1;
    #1;
    chk("en_flush0", 32'(flush), 0);
    step(2);
    chk("en_frozen", {29'd0, redirect_valid, in_handler, halted}, 32'b100);
    redirect_ready = 1'b0; enable = 1'b1;
    #1;
    chk("en_flush1", 32'(flush), 1);
    step(1);
    // Async reset while REDIRECT is pending drops the redirect.
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst", {redirect_valid, cause, flush, in_handler, halted, gie}, 0);
    chk("mid_rst_a", redirect_addr | epc | bad_addr, 0);
    step(1);
    reset = 1'b0;

    trigger = 3'd1; pc_current = 32'h4000;
    push(32'h110, 5'd1, 32'h4000, 32'h4000);
    step(1);
    trigger = '0; redirect_ready = 1'b1;
    step(2);
    redirect_ready = 1'b0;
    chk("insta_inh", 32'(in_handler), 1);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
